otter_iobus_periph: RTL and testbench

- Parametrised memory-mapped IO peripheral for the OTTER MCU IOBUS.
- Replaces hand-coded wrapper decode with N input ports, N output registers and a cycle timer.
- Timer has a coherent 64-bit read, a compare match and an interrupt output.
- Sits between the OTTER_MCU IOBUS signals and board peripherals (switches, LEDs, seven-segment display).

---
 rtl/otter_iobus_periph.sv | 181 ++++++++++++++++++
 tb/tb_otter_iobus_periph.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/otter_iobus_periph.sv
// otter_iobus_periph
//   Memory-mapped IO peripheral for the OTTER MCU IOBUS: N_IN synchronised
//   input ports, N_OUT output registers and a CNT_W-bit cycle timer with
//   coherent 64-bit read, compare match and a level interrupt.
//
// Ports
//   CLK         MCU clock, all state on posedge
//   RST_N       asynchronous active-low reset
//   IOBUS_ADDR  byte address from MCU
//   IOBUS_OUT   write data from MCU
//   IOBUS_WR    write strobe (one cycle per store)
//   IOBUS_RD    read strobe (one cycle per load)
//   IOBUS_IN    read data to MCU, combinational from IOBUS_ADDR
//   IN_PORTS    asynchronous board inputs, port i = [i*IN_W +: IN_W]
//   OUT_PORTS   output register contents, same packing
//   IRQ         registered level interrupt
//
// Optional feature macro: OTTER_IOBUS_PRESCALE_EN
//   Adds a 16-bit PRESCALE register at offset 0x400018; the timer then
//   advances once every PRESCALE+1 cycles. Undefined: timer ticks every cycle.
module otter_iobus_periph #(
    parameter logic [31:0] BASE_AD = 32'h1100_0000,
    parameter int          N_IN    = 1,
    parameter int          IN_W    = 16,
    parameter int          N_OUT   = 2,
    parameter int          OUT_W   = 16,
    parameter int          CNT_W   = 64
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [31:0]            IOBUS_ADDR,
    input  logic [31:0]            IOBUS_OUT,
    input  logic                   IOBUS_WR,
    input  logic                   IOBUS_RD,
    output logic [31:0]            IOBUS_IN,
    input  logic [N_IN*IN_W-1:0]   IN_PORTS,
    output logic [N_OUT*OUT_W-1:0] OUT_PORTS,
    output logic                   IRQ
);

    localparam int          HI_W      = CNT_W - 32;
    localparam logic [31:0] OFF_IN    = 32'h0000_0000;
    localparam logic [31:0] OFF_OUT   = 32'h0008_0000;
    localparam logic [31:0] OFF_CNTLO = 32'h0040_0000;
    localparam logic [31:0] OFF_CNTHI = 32'h0040_0004;
    localparam logic [31:0] OFF_CMPLO = 32'h0040_0008;
    localparam logic [31:0] OFF_CMPHI = 32'h0040_000C;
    localparam logic [31:0] OFF_CTRL  = 32'h0040_0010;
    localparam logic [31:0] OFF_STAT  = 32'h0040_0014;

    logic [31:0] off;
    assign off = IOBUS_ADDR - BASE_AD;

    logic wr_cntlo, wr_cnthi, wr_cmplo, wr_cmphi, wr_ctrl, wr_stat, wr_cnt, wr_cmp;
    assign wr_cntlo = IOBUS_WR && (off == OFF_CNTLO);
    assign wr_cnthi = IOBUS_WR && (off == OFF_CNTHI);
    assign wr_cmplo = IOBUS_WR && (off == OFF_CMPLO);
    assign wr_cmphi = IOBUS_WR && (off == OFF_CMPHI);
    assign wr_ctrl  = IOBUS_WR && (off == OFF_CTRL);
    assign wr_stat  = IOBUS_WR && (off == OFF_STAT);
    assign wr_cnt   = wr_cntlo || wr_cnthi;
    assign wr_cmp   = wr_cmplo || wr_cmphi;

    logic [N_IN*IN_W-1:0]   sync1_q, sync2_q;
    logic [N_OUT*OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cmp_q, cmp_d;
    logic [HI_W-1:0]        shadow_q, shadow_d;
    logic [1:0]             ctrl_q, ctrl_d, status_q, status_d;
    logic                   irq_q, irq_d;
    logic                   tick, cnt_inc, ovf_ev, match_ev;

    // Upper write-data bits are unused for narrow registers.
    logic unused_bits;
    assign unused_bits = ^IOBUS_OUT;

`ifdef OTTER_IOBUS_PRESCALE_EN
    localparam logic [31:0] OFF_PRE = 32'h0040_0018;
    logic        wr_pre;
    logic [15:0] pre_q, pre_d, pcnt_q, pcnt_d;
    assign wr_pre = IOBUS_WR && (off == OFF_PRE);
    assign tick   = (pcnt_q == pre_q);
    // Any timebase write restarts the prescale phase so software sees a full period.
    assign pcnt_d = (wr_pre || wr_cnt || tick) ? 16'd0 : pcnt_q + 16'd1;
    assign pre_d  = wr_pre ? IOBUS_OUT[15:0] : pre_q;
`else
    assign tick = 1'b1;
`endif

    // A counter write wins over the increment, and any timebase write masks
    // the compare so a half-written value cannot raise a spurious match.
    assign cnt_inc  = tick && ctrl_q[0] && !wr_cnt;
    assign ovf_ev   = cnt_inc && (&cnt_q);
    assign match_ev = tick && ctrl_q[0] && !wr_cnt && !wr_cmp && (cnt_q == cmp_q);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (IOBUS_WR && (off == OFF_OUT + 32'(4 * i)))
                out_d[i*OUT_W +: OUT_W] = IOBUS_OUT[OUT_W-1:0];
        end

        cnt_d = cnt_inc ? cnt_q + CNT_W'(1) : cnt_q;
        if (wr_cntlo) cnt_d[31:0]       = IOBUS_OUT;
        if (wr_cnthi) cnt_d[CNT_W-1:32] = IOBUS_OUT[HI_W-1:0];

        cmp_d = cmp_q;
        if (wr_cmplo) cmp_d[31:0]       = IOBUS_OUT;
        if (wr_cmphi) cmp_d[CNT_W-1:32] = IOBUS_OUT[HI_W-1:0];

        // Latch the high half at the LO read so a following HI read is coherent.
        shadow_d = (IOBUS_RD && (off == OFF_CNTLO)) ? cnt_q[CNT_W-1:32] : shadow_q;
        ctrl_d   = wr_ctrl ? IOBUS_OUT[1:0] : ctrl_q;
        // Clear first, then set, so a simultaneous event is never lost.
        status_d = (status_q & ~(wr_stat ? IOBUS_OUT[1:0] : 2'b00)) | {ovf_ev, match_ev};
        irq_d    = status_q[0] & ctrl_q[1];
    end

    always_comb begin
        IOBUS_IN = 32'd0;
        for (int i = 0; i < N_IN; i++) begin
            if (off == OFF_IN + 32'(4 * i)) IOBUS_IN = 32'(sync2_q[i*IN_W +: IN_W]);
        end
        for (int i = 0; i < N_OUT; i++) begin
            if (off == OFF_OUT + 32'(4 * i)) IOBUS_IN = 32'(out_q[i*OUT_W +: OUT_W]);
        end
        case (off)
            OFF_CNTLO: IOBUS_IN = cnt_q[31:0];
            OFF_CNTHI: IOBUS_IN = 32'(shadow_q);
            OFF_CMPLO: IOBUS_IN = cmp_q[31:0];
            OFF_CMPHI: IOBUS_IN = 32'(cmp_q[CNT_W-1:32]);
            OFF_CTRL:  IOBUS_IN = {30'd0, ctrl_q};
            OFF_STAT:  IOBUS_IN = {30'd0, status_q};
`ifdef OTTER_IOBUS_PRESCALE_EN
            OFF_PRE:   IOBUS_IN = {16'd0, pre_q};
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            cmp_q    <= '1;
            shadow_q <= '0;
            ctrl_q   <= 2'b01;
            status_q <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= IN_PORTS;
            sync2_q  <= sync1_q;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

`ifdef OTTER_IOBUS_PRESCALE_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_q  <= 16'd0;
            pcnt_q <= 16'd0;
        end else begin
            pre_q  <= pre_d;
            pcnt_q <= pcnt_d;
        end
    end
`endif

    assign OUT_PORTS = out_q;
    assign IRQ       = irq_q;

endmodule

// File: tb/tb_otter_iobus_periph.sv
// Directed bench for otter_iobus_periph with a read-data scoreboard.
// Optional feature macro: OTTER_IOBUS_PRESCALE_EN (enables prescale section).
module tb_otter_iobus_periph;

    localparam logic [31:0] BASE = 32'h1100_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, iobus_in;
    logic        wr, rd;
    logic [15:0] in_ports;
    logic [31:0] out_ports;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    otter_iobus_periph dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .IOBUS_ADDR (addr),
        .IOBUS_OUT  (wdata),
        .IOBUS_WR   (wr),
        .IOBUS_RD   (rd),
        .IOBUS_IN   (iobus_in),
        .IN_PORTS   (in_ports),
        .OUT_PORTS  (out_ports),
        .IRQ        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; occupies exactly one posedge and returns at the next negedge.
    task automatic bus_read(input string tag, input logic [31:0] off, input logic [31:0] exp);
        string       t;
        logic [31:0] e;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        addr = BASE + off;
        rd   = 1'b1;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, iobus_in, e);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        addr  = BASE + off;
        wdata = data;
        wr    = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Write while also checking the combinational read value seen before the edge.
    task automatic bus_write_chk(input string tag, input logic [31:0] off,
                                 input logic [31:0] data, input logic [31:0] exp);
        string       t;
        logic [31:0] e;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        addr  = BASE + off;
        wdata = data;
        wr    = 1'b1;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, iobus_in, e);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; addr = BASE; wdata = '0; wr = 1'b0; rd = 1'b0; in_ports = '0;

        // Reset state
        #3;
        check("rst_out_ports", out_ports, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        check("rst_ctrl", {30'd0, dut.ctrl_q}, 32'h1);
        rst_n = 1'b1;

        // First count on the first posedge after release
        bus_read("cnt_first0", 32'h40_0000, 32'd0);
        bus_read("cnt_first1", 32'h40_0000, 32'd1);
        bus_read("rst_cmplo", 32'h40_0008, 32'hFFFF_FFFF);
        bus_read("rst_cmphi", 32'h40_000C, 32'hFFFF_FFFF);
        bus_read("rst_stat", 32'h40_0014, 32'h0);
        bus_read("rst_ctrl_rd", 32'h40_0010, 32'h1);

        // Input synchroniser latency
        in_ports = 16'hA5A5;
        bus_read("in_sync_e0", 32'h0, 32'h0);
        bus_read("in_sync_e1", 32'h0, 32'h0);
        bus_read("in_sync_e2", 32'h0, 32'h0000_A5A5);

        // Output registers
        bus_write(32'h8_0004, 32'hFFFF_1234);
        check("out_ports", out_ports, 32'h1234_0000);
        bus_read("out1_rd", 32'h8_0004, 32'h0000_1234);
        bus_read("out0_rd", 32'h8_0000, 32'h0);

        // Unmapped accesses
        bus_write(32'h8_0008, 32'hFFFF_FFFF);
        check("unmapped_wr", out_ports, 32'h1234_0000);
        bus_read("unmapped_in1", 32'h4, 32'h0);
        bus_read("unmapped_418", 32'h40_0018, 32'h0);
        bus_read("unmapped_420", 32'h40_0020, 32'h0);

        // Coherent read across a low-half wrap
        bus_write(32'h40_0010, 32'hFFFF_FFFC);
        bus_read("ctrl_hibits", 32'h40_0010, 32'h0);
        bus_write(32'h40_0000, 32'hFFFF_FFFF);
        bus_write(32'h40_0004, 32'h0);
        bus_write(32'h40_0010, 32'h1);
        bus_read("coh_lo", 32'h40_0000, 32'hFFFF_FFFF);
        bus_read("coh_hi0", 32'h40_0004, 32'h0);
        bus_read("coh_lo2", 32'h40_0000, 32'h1);
        bus_read("coh_hi1", 32'h40_0004, 32'h1);

        // Compare match and interrupt
        bus_write(32'h40_0008, 32'd20);
        bus_write(32'h40_000C, 32'd0);
        bus_write(32'h40_0004, 32'd0);
        bus_write(32'h40_0000, 32'd0);
        bus_write(32'h40_0014, 32'h3);
        bus_write(32'h40_0010, 32'h3);
        idle(17);
        bus_read("cmp_before", 32'h40_0014, 32'h0);
        bus_read("cmp_cnt20", 32'h40_0000, 32'd20);
        check("irq_lag", {31'd0, irq}, 32'h0);
        bus_read("cmp_match", 32'h40_0014, 32'h1);
        check("irq_set", {31'd0, irq}, 32'h1);
        bus_write(32'h40_0014, 32'h1);
        idle(1);
        check("irq_clr", {31'd0, irq}, 32'h0);
        bus_read("stat_clr", 32'h40_0014, 32'h0);

        // Overflow wrap and set-beats-clear
        bus_write(32'h40_0010, 32'h0);
        bus_write(32'h40_0000, 32'hFFFF_FFFF);
        bus_write(32'h40_0004, 32'hFFFF_FFFF);
        bus_write(32'h40_0008, 32'h0);
        bus_write(32'h40_000C, 32'h0);
        bus_write(32'h40_0014, 32'h3);
        bus_write(32'h40_0010, 32'h1);
        bus_read("ovf_before", 32'h40_0014, 32'h0);
        bus_write_chk("ovf_set", 32'h40_0014, 32'h2, 32'h2);
        bus_read("ovf_cnt", 32'h40_0000, 32'h1);
        bus_read("ovf_clr_match", 32'h40_0014, 32'h1);

        // Raise IRQ ahead of the asynchronous reset check
        bus_write(32'h40_0010, 32'h3);
        idle(1);
        check("irq_pre_rst", {31'd0, irq}, 32'h1);

`ifdef OTTER_IOBUS_PRESCALE_EN
        bus_write(32'h40_0010, 32'h2);
        bus_write(32'h40_0018, 32'd3);
        bus_read("pre_rd", 32'h40_0018, 32'd3);
        bus_write(32'h40_0010, 32'h3);
        bus_write(32'h40_0004, 32'h0);
        bus_write(32'h40_0000, 32'h0);
        for (int i = 0; i < 9; i++) begin
            bus_read($sformatf("pre_cnt%0d", i), 32'h40_0000, 32'(i / 4));
        end
`endif

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        addr  = BASE + 32'h40_0000;
        #1;
        check("arst_cnt", iobus_in, 32'h0);
        check("arst_irq", {31'd0, irq}, 32'h0);
        check("arst_out", out_ports, 32'h0);
        addr = BASE + 32'h40_0018;
        #1;
        check("arst_pre", iobus_in, 32'h0);

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
